// File: rtl/step_debounce_pkg.sv
// Shared constants and FSM encodings for the step push-button debouncer.
// Imported by the debouncer top and its synchronizer.
package step_debounce_pkg;

    localparam logic F   = 1'b1;
    localparam logic R   = 1'b0;
    localparam logic LOW = 1'b0;
    localparam logic HI  = 1'b1;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } btn_state_t;

    // Counter width for a debounce window of n cycles (never below 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_debounce_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RST_VAL so the synchronized level starts defined.
module sync2
    import step_debounce_pkg::*;
#(
    parameter logic RST_VAL = HI
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/step_debounce.sv
// Debounces a step push-button and a direction switch, issuing one
// step pulse per accepted press and a direction that only moves when idle.
module step_debounce
    import step_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       sw_dir,
    output logic       step,
    output logic       dir,
    output logic       busy,
    output logic [7:0] step_cnt
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic w_key_s;
    logic w_dir_s;

    btn_state_t    r_state;
    btn_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_press_done;
    logic          w_busy;
    logic          w_idle;

    logic          r_step;
    logic [7:0]    r_step_cnt;
    logic          r_dir;
    logic [CW-1:0] r_dcnt;

    sync2 #(.RST_VAL(HI)) u_sync_key (
        .clk (clk),
        .rst (rst),
        .i_d (key_n),
        .o_q (w_key_s)
    );

    sync2 #(.RST_VAL(F)) u_sync_dir (
        .clk (clk),
        .rst (rst),
        .i_d (sw_dir),
        .o_q (w_dir_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Press and release share one counter; a contrary sample restarts the wait.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_press_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_key_s == LOW) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (w_key_s == HI) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt  = HELD;
                    w_press_done = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (w_key_s == HI) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_key_s == LOW) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE);
        w_idle = ~w_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step     <= 1'b0;
            r_step_cnt <= 8'd0;
        end else begin
            r_step     <= w_press_done;
            r_step_cnt <= r_step_cnt + {7'd0, w_press_done};
        end
    end

    // A saturated direction counter waits here until the button FSM is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir  <= F;
            r_dcnt <= '0;
        end else if (w_dir_s == r_dir) begin
            r_dcnt <= '0;
        end else if (r_dcnt == CNT_MAX) begin
            if (w_idle) begin
                r_dir  <= w_dir_s;
                r_dcnt <= '0;
            end
        end else begin
            r_dcnt <= r_dcnt + CNT_ONE;
        end
    end

    assign step     = r_step;
    assign dir      = r_dir;
    assign busy     = w_busy;
    assign step_cnt = r_step_cnt;

endmodule

// File: tb/tb_step_debounce.sv
// Self-checking bench for step_debounce against a run-length reference model.
// Directed scenarios plus randomized key/switch traffic, checked every cycle.
module tb_step_debounce;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       key_n;
    logic       sw_dir;
    logic       step;
    logic       dir;
    logic       busy;
    logic [7:0] step_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: synchronizer pipe plus run lengths of stable samples.
    logic       m_k1, m_k2, m_d1, m_d2;
    bit         m_pressed;
    int         m_run;
    int         m_drun;
    logic       m_dir;
    logic       m_step;
    logic [7:0] m_cnt;
    int         m_edges = 0;

    step_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_n    (key_n),
        .sw_dir   (sw_dir),
        .step     (step),
        .dir      (dir),
        .busy     (busy),
        .step_cnt (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_busy();
        return m_pressed || (m_run != 0);
    endfunction

    task automatic model_edge();
        logic busy_pre;
        logic ks;
        logic ds;
        busy_pre = m_busy();
        ks = m_k2;
        ds = m_d2;
        m_edges++;
        if (rst) begin
            m_k1 = 1'b1; m_k2 = 1'b1;
            m_d1 = 1'b1; m_d2 = 1'b1;
            m_pressed = 0; m_run = 0; m_drun = 0;
            m_dir = 1'b1; m_step = 1'b0; m_cnt = 8'd0;
        end else begin
            m_step = 1'b0;
            if (!m_pressed) begin
                if (ks == 1'b0) begin
                    m_run++;
                    if (m_run == N + 1) begin
                        m_pressed = 1; m_run = 0;
                        m_step = 1'b1; m_cnt = m_cnt + 8'd1;
                    end
                end else m_run = 0;
            end else begin
                if (ks == 1'b1) begin
                    m_run++;
                    if (m_run == N + 1) begin
                        m_pressed = 0; m_run = 0;
                    end
                end else m_run = 0;
            end
            if (ds != m_dir) begin
                m_drun++;
                if (m_drun >= N && !busy_pre) begin
                    m_dir = ds; m_drun = 0;
                end
            end else m_drun = 0;
            m_k2 = m_k1; m_k1 = key_n;
            m_d2 = m_d1; m_d1 = sw_dir;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_n = 1'b1; sw_dir = 1'b0;
        tick(); tick();
        n_tests++;
        if ({step, dir, busy, step_cnt} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_vals: got step=%0b dir=%0b busy=%0b cnt=%0d want 0 1 0 0",
                     step, dir, busy, step_cnt);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (dir !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_dir_hold cyc%0d: got dir=%0b want 1", i, dir);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if ({step, dir, busy, step_cnt} !== {m_step, m_dir, m_busy(), m_cnt}) begin
                n_fail++;
                $display("FAIL reset_settle cyc%0d: got %0b%0b%0b/%0d want %0b%0b%0b/%0d",
                         i, step, dir, busy, step_cnt, m_step, m_dir, m_busy(), m_cnt);
            end
        end
        n_tests++;
        if (dir !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dir_follow: got dir=%0b want 0", dir);
        end
    endtask

    task automatic test_clean_press();
        int first;
        int lat;
        int pulses;
        logic [7:0] cnt0;
        cnt0 = step_cnt;
        pulses = 0; lat = -1;
        key_n = 1'b0;
        first = m_edges + 1;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) key_n = 1'b1;
            tick();
            if (step === 1'b1) begin
                pulses++;
                if (lat < 0) lat = m_edges - first + 1;
            end
            n_tests++;
            if ({step, dir, busy, step_cnt} !== {m_step, m_dir, m_busy(), m_cnt}) begin
                n_fail++;
                $display("FAIL clean_cyc%0d: got %0b%0b%0b/%0d want %0b%0b%0b/%0d",
                         i, step, dir, busy, step_cnt, m_step, m_dir, m_busy(), m_cnt);
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL clean_pulses: got %0d want 1", pulses);
        end
        n_tests++;
        if (lat != N + 3) begin
            n_fail++;
            $display("FAIL clean_latency: got %0d edges want %0d", lat, N + 3);
        end
        n_tests++;
        if (step_cnt !== cnt0 + 8'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_end: got cnt=%0d busy=%0b want cnt=%0d busy=0",
                     step_cnt, busy, cnt0 + 8'd1);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        int rel_pulses;
        logic [7:0] cnt0;
        cnt0 = step_cnt;
        pulses = 0; rel_pulses = 0;
        for (int i = 0; i < 64; i++) begin
            if (i < 12)      key_n = ((i / 2) % 2 == 1);
            else if (i < 32) key_n = 1'b0;
            else if (i < 44) key_n = ((i / 2) % 2 == 0);
            else             key_n = 1'b1;
            tick();
            if (step === 1'b1) begin
                pulses++;
                if (i >= 32) rel_pulses++;
            end
            n_tests++;
            if ({step, dir, busy, step_cnt} !== {m_step, m_dir, m_busy(), m_cnt}) begin
                n_fail++;
                $display("FAIL bounce_cyc%0d: got %0b%0b%0b/%0d want %0b%0b%0b/%0d",
                         i, step, dir, busy, step_cnt, m_step, m_dir, m_busy(), m_cnt);
            end
        end
        n_tests++;
        if (pulses != 1 || rel_pulses != 0) begin
            n_fail++;
            $display("FAIL bounce_pulses: got %0d (release %0d) want 1 (release 0)",
                     pulses, rel_pulses);
        end
        n_tests++;
        if (step_cnt !== cnt0 + 8'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_end: got cnt=%0d busy=%0b want cnt=%0d busy=0",
                     step_cnt, busy, cnt0 + 8'd1);
        end
    endtask

    task automatic test_glitch();
        int pulses;
        logic [7:0] cnt0;
        cnt0 = step_cnt;
        pulses = 0;
        for (int i = 0; i < 18; i++) begin
            key_n = (i >= 3);
            tick();
            if (step === 1'b1) pulses++;
            n_tests++;
            if ({step, dir, busy, step_cnt} !== {m_step, m_dir, m_busy(), m_cnt}) begin
                n_fail++;
                $display("FAIL glitch_cyc%0d: got %0b%0b%0b/%0d want %0b%0b%0b/%0d",
                         i, step, dir, busy, step_cnt, m_step, m_dir, m_busy(), m_cnt);
            end
        end
        n_tests++;
        if (pulses != 0 || step_cnt !== cnt0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_end: got pulses=%0d cnt=%0d busy=%0b want 0 %0d 0",
                     pulses, step_cnt, busy, cnt0);
        end
    endtask

    task automatic test_dir_holdoff();
        int guard;
        int bad;
        bad = 0;
        sw_dir = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (dir !== 1'b1) begin
            n_fail++;
            $display("FAIL holdoff_prep: got dir=%0b want 1", dir);
        end
        key_n = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        sw_dir = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (dir !== 1'b1) bad++;
        end
        key_n = 1'b1;
        guard = 0;
        while (busy === 1'b1 && guard < 30) begin
            tick();
            guard++;
            if (busy === 1'b1 && dir !== 1'b1) bad++;
        end
        n_tests++;
        if (guard >= 30) begin
            n_fail++;
            $display("FAIL holdoff_timeout: busy=%0b after %0d cycles want 0", busy, guard);
        end
        n_tests++;
        if (bad != 0 || dir !== 1'b1) begin
            n_fail++;
            $display("FAIL holdoff_busy: got %0d early changes dir=%0b want 0 changes dir=1",
                     bad, dir);
        end
        tick();
        n_tests++;
        if (dir !== 1'b0 || dir !== m_dir) begin
            n_fail++;
            $display("FAIL holdoff_idle: got dir=%0b want 0", dir);
        end
        sw_dir = 1'b1;
        tick(); tick();
        sw_dir = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dir !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL dir_glitch: got %0d cycles with dir=1 want 0", bad);
        end
    endtask

    task automatic test_random();
        int klen;
        int dlen;
        int pulses;
        pulses = 0; klen = 0; dlen = 0;
        for (int i = 0; i < 2000; i++) begin
            if (klen == 0) begin
                key_n = ~key_n;
                klen = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20)
                                                   : $urandom_range(1, 6);
            end
            if (dlen == 0) begin
                sw_dir = ~sw_dir;
                dlen = $urandom_range(1, 40);
            end
            klen--; dlen--;
            tick();
            if (step === 1'b1) pulses++;
            n_tests++;
            if ({step, dir, busy, step_cnt} !== {m_step, m_dir, m_busy(), m_cnt}) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %0b%0b%0b/%0d want %0b%0b%0b/%0d",
                         i, step, dir, busy, step_cnt, m_step, m_dir, m_busy(), m_cnt);
            end
        end
        n_tests++;
        if (pulses == 0) begin
            n_fail++;
            $display("FAIL random_activity: got 0 pulses want >0");
        end
    endtask

    task automatic test_wrap();
        int pulses;
        int bad;
        pulses = 0; bad = 0;
        rst = 1'b1; key_n = 1'b1; sw_dir = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int p = 0; p < 256; p++) begin
            for (int c = 0; c < 16; c++) begin
                key_n = (c >= 8);
                tick();
                if (step === 1'b1) pulses++;
                if ({step, dir, busy, step_cnt} !== {m_step, m_dir, m_busy(), m_cnt})
                    bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap_cycles: got %0d model differences want 0", bad);
        end
        n_tests++;
        if (pulses != 256 || step_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_count: got pulses=%0d cnt=%0d want 256 0", pulses, step_cnt);
        end
    endtask

    task automatic test_abort();
        int pulses;
        pulses = 0;
        key_n = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_prep: got busy=%0b want 1", busy);
        end
        rst = 1'b1; key_n = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({step, busy, step_cnt} !== {1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL abort_rst: got step=%0b busy=%0b cnt=%0d want 0 0 0",
                     step, busy, step_cnt);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (step === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0 || busy !== 1'b0 || step_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_after: got pulses=%0d busy=%0b cnt=%0d want 0 0 0",
                     pulses, busy, step_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; key_n = 1'b1; sw_dir = 1'b0;
        m_k1 = 1'b1; m_k2 = 1'b1; m_d1 = 1'b1; m_d2 = 1'b1;
        m_pressed = 0; m_run = 0; m_drun = 0;
        m_dir = 1'b1; m_step = 1'b0; m_cnt = 8'd0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_dir_holdoff();
        test_random();
        test_wrap();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/step_debounce.md
STEP_DEBOUNCE -- requirements
Module: step_debounce

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable clk cycles needed to accept an input level; 4 is the simulation value, 500000 is the 50 MHz board value; legal range >= 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: key_n  input  1  raw step push-button, active-low, asynchronous to clk, may bounce.
REQ-005 Port: sw_dir  input  1  raw direction switch (1 = forward F, 0 = reverse R), asynchronous, may bounce.
REQ-006 Port: step  output  1  single-cycle pulse, one per accepted press; drives the downstream FSM step/clock-enable.
REQ-007 Port: dir  output  1  debounced direction; downstream FSM direction input.
REQ-008 Port: busy  output  1  high whenever the button state machine is not IDLE.
REQ-009 Port: step_cnt  output  8  count of step pulses issued, modulo 256.

Function
REQ-010 key_n and sw_dir shall each pass through a 2-flop synchronizer before any other use (key_s, dir_s).
REQ-011 Button FSM states shall be IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, sharing one counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 IDLE: on key_s=0, go to PRESS_WAIT and clear the counter; otherwise stay in IDLE.
REQ-013 PRESS_WAIT: on key_s=1, go to IDLE; else if counter = DEBOUNCE_CYCLES-1, go to HELD; else increment the counter.
REQ-014 HELD: on key_s=1, go to RELEASE_WAIT and clear the counter; otherwise stay in HELD.
REQ-015 RELEASE_WAIT: on key_s=0, go to HELD without a new step; else if counter = DEBOUNCE_CYCLES-1, go to IDLE; else increment the counter.
REQ-016 step shall be registered and high only in the first cycle after the PRESS_WAIT->HELD transition, i.e. DEBOUNCE_CYCLES+3 rising edges after the first edge that samples key_n=0 (7 edges at the default).
REQ-017 A press shorter than DEBOUNCE_CYCLES stable cycles shall produce no step, and a bouncing release shall never produce a step.
REQ-018 step_cnt shall increment by 1 in the same cycle that step is high, wrapping from 255 to 0.
REQ-019 Direction debouncer: a counter shall clear whenever dir_s equals dir, and otherwise increment, saturating at DEBOUNCE_CYCLES-1.
REQ-020 dir shall take the value of dir_s only when that counter is saturated and the button FSM is IDLE, so dir never changes while busy=1 or while step=1.
REQ-021 If the direction counter saturates while busy=1, the update shall be deferred to the first IDLE cycle, provided dir_s still differs from dir.
REQ-022 busy shall be combinational, equal to (state != IDLE).

Reset
REQ-023 With rst=1 at a rising edge, the next values shall be:
- state IDLE; both counters 0
- step 0, step_cnt 0, dir 1 (F)
- synchronizer flops: key path 1 (released), dir path 1
REQ-024 rst asserted in any state, including mid PRESS_WAIT, shall abort the operation with no step pulse; rst has priority over all other inputs.

Structure
REQ-025 The shared defines header shall hold:
- the direction constants F=1 and R=0
- the LOW/HI constants
- the FSM state encodings IDLE=2'b00, PRESS_WAIT=2'b01, HELD=2'b10, RELEASE_WAIT=2'b11
REQ-026 The 2-flop synchronizer shall be a sub-module named sync2, instantiated twice; the debounce logic shall stay in step_debounce.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset: rst=1 for 2 cycles, key_n=1, sw_dir=0 -> step=0, dir=1, step_cnt=0, busy=0; no dir change until 4 cycles after rst drops.
REQ-028 Clean press: key_n=0 for 20 cycles, then 1 for 20 cycles -> exactly one step pulse, 7 edges after the first low sample; step_cnt=1; busy=0 at the end.
REQ-029 Bounce: key_n toggles every 2 cycles for 12 cycles, then stays 0, then release bounces similarly -> exactly one step pulse, no pulse on release; step_cnt=1.
REQ-030 Glitch: key_n=0 for 3 cycles only -> no step; FSM returns to IDLE; step_cnt unchanged.
REQ-031 Direction hold-off: sw_dir 1->0 while key held -> dir stays 1 until busy=0, then dir=0 in the first IDLE cycle; a 2-cycle sw_dir glitch -> dir unchanged.
REQ-032 Wrap and abort: 256 clean presses -> step_cnt=0; rst=1 mid PRESS_WAIT -> no step, state IDLE.
